butterfly_2: RTL and testbench

BUTTERFLY_2 -- requirements
Module: butterfly_2

---
 rtl/fft_2_pkg.sv | 15 +
 rtl/saturate_2.sv | 30 +++
 rtl/butterfly_2.sv | 186 ++++++++++++++++++
 tb/tb_butterfly_2.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_2_pkg.sv
// Shared defaults and FSM encoding for the radix-2 butterfly.
// The state encoding is kept as plain constants so legacy users can compare raw bits.
package fft_2_pkg;

  localparam int WIDTH_DEF      = 12;
  localparam int PROD_WIDTH_DEF = 24;
  localparam int TIMEOUT_DEF    = 16;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/saturate_2.sv
// Clamps a wide signed product into the narrower signed sample range.
// The sat output flags that clamping took place.
module saturate_2
  import fft_2_pkg::*;
#(
  parameter int IN_W  = PROD_WIDTH_DEF,
  parameter int OUT_W = WIDTH_DEF
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // Range limits expressed at the input width so comparisons stay signed and exact.
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    dout = din[OUT_W-1:0];
    sat  = 1'b0;
    if (din > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/butterfly_2.sv
// Radix-2 butterfly: a = (x + p) >>> 1, b = (x - p) >>> 1, with p the saturated
// twiddle product delivered by an external multiplier after a bounded wait.
module butterfly_2
  import fft_2_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [WIDTH-1:0]      x_real,
  input  logic signed [WIDTH-1:0]      x_img,
  input  logic signed [PROD_WIDTH-1:0] prod_real,
  input  logic signed [PROD_WIDTH-1:0] prod_img,
  input  logic                         prod_rdy,
  output logic                         busy,
  output logic                         out_valid,
  output logic signed [WIDTH-1:0]      a_real,
  output logic signed [WIDTH-1:0]      a_img,
  output logic signed [WIDTH-1:0]      b_real,
  output logic signed [WIDTH-1:0]      b_img,
  output logic                         sat_flag,
  output logic                         timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [WIDTH-1:0] x_re_q, x_re_d;
  logic signed [WIDTH-1:0] x_im_q, x_im_d;
  logic signed [WIDTH-1:0] p_re_q, p_re_d;
  logic signed [WIDTH-1:0] p_im_q, p_im_d;
  logic                    psat_q, psat_d;

  logic signed [WIDTH-1:0] a_re_q, a_re_d;
  logic signed [WIDTH-1:0] a_im_q, a_im_d;
  logic signed [WIDTH-1:0] b_re_q, b_re_d;
  logic signed [WIDTH-1:0] b_im_q, b_im_d;
  logic                    sat_flag_q, sat_flag_d;
  logic                    out_valid_q, out_valid_d;
  logic                    timeout_q, timeout_d;

  logic signed [WIDTH-1:0] p_re_sat, p_im_sat;
  logic                    sat_re, sat_im;

  // Sums are widened by one bit, so the halved result always fits back in WIDTH.
  function automatic logic signed [WIDTH-1:0] half_sum(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] p
  );
    logic signed [WIDTH:0] s;
    s = {x[WIDTH-1], x} + {p[WIDTH-1], p};
    return WIDTH'(s >>> 1);
  endfunction

  function automatic logic signed [WIDTH-1:0] half_dif(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] p
  );
    logic signed [WIDTH:0] s;
    s = {x[WIDTH-1], x} - {p[WIDTH-1], p};
    return WIDTH'(s >>> 1);
  endfunction

  saturate_2 #(
    .IN_W  (PROD_WIDTH),
    .OUT_W (WIDTH)
  ) u_sat_re (
    .din  (prod_real),
    .dout (p_re_sat),
    .sat  (sat_re)
  );

  saturate_2 #(
    .IN_W  (PROD_WIDTH),
    .OUT_W (WIDTH)
  ) u_sat_im (
    .din  (prod_img),
    .dout (p_im_sat),
    .sat  (sat_im)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_re_d      = x_re_q;
    x_im_d      = x_im_q;
    p_re_d      = p_re_q;
    p_im_d      = p_im_q;
    psat_d      = psat_q;
    a_re_d      = a_re_q;
    a_im_d      = a_im_q;
    b_re_d      = b_re_q;
    b_im_d      = b_im_q;
    sat_flag_d  = sat_flag_q;
    out_valid_d = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_re_d  = x_real;
          x_im_d  = x_img;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      // A product arriving on the last allowed cycle still wins over the abort.
      ST_WAIT: begin
        if (prod_rdy) begin
          p_re_d  = p_re_sat;
          p_im_d  = p_im_sat;
          psat_d  = sat_re | sat_im;
          state_d = ST_OUT;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_OUT: begin
        a_re_d      = half_sum(x_re_q, p_re_q);
        a_im_d      = half_sum(x_im_q, p_im_q);
        b_re_d      = half_dif(x_re_q, p_re_q);
        b_im_d      = half_dif(x_im_q, p_im_q);
        sat_flag_d  = psat_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_re_q      <= '0;
      x_im_q      <= '0;
      p_re_q      <= '0;
      p_im_q      <= '0;
      psat_q      <= 1'b0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      sat_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_re_q      <= x_re_d;
      x_im_q      <= x_im_d;
      p_re_q      <= p_re_d;
      p_im_q      <= p_im_d;
      psat_q      <= psat_d;
      a_re_q      <= a_re_d;
      a_im_q      <= a_im_d;
      b_re_q      <= b_re_d;
      b_im_q      <= b_im_d;
      sat_flag_q  <= sat_flag_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign a_real    = a_re_q;
  assign a_img     = a_im_q;
  assign b_real    = b_re_q;
  assign b_img     = b_im_q;
  assign sat_flag  = sat_flag_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_butterfly_2.sv
// Table-driven bench for butterfly_2 with a result scoreboard and corner sequences.
module tb_butterfly_2;

  localparam int W  = 12;
  localparam int PW = 24;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 prod_rdy;
  logic signed [W-1:0]  x_real, x_img;
  logic signed [PW-1:0] prod_real, prod_img;
  logic                 busy, out_valid, sat_flag, timeout;
  logic signed [W-1:0]  a_real, a_img, b_real, b_img;

  butterfly_2 #(.WIDTH(W), .PROD_WIDTH(PW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_real    (x_real),
    .x_img     (x_img),
    .prod_real (prod_real),
    .prod_img  (prod_img),
    .prod_rdy  (prod_rdy),
    .busy      (busy),
    .out_valid (out_valid),
    .a_real    (a_real),
    .a_img     (a_img),
    .b_real    (b_real),
    .b_img     (b_img),
    .sat_flag  (sat_flag),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {int ar; int ai; int br; int bi; int sat; int cyc;} exp_t;
  typedef struct {int xr; int xi; int pr; int pi; int k; int ar; int ai; int br; int bi; int sat;} vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int last_ar = 0, last_ai = 0, last_br = 0, last_bi = 0, last_sat = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat12(input int p);
    if (p > 2047) return 2047;
    if (p < -2048) return -2048;
    return p;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("a_real", int'(a_real), e.ar);
        chk("a_img", int'(a_img), e.ai);
        chk("b_real", int'(b_real), e.br);
        chk("b_img", int'(b_img), e.bi);
        chk("sat_flag", int'(sat_flag), e.sat);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    chk("out_valid_missing", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_op(input int xr, input int xi, input int pr, input int pi, input int k,
                        input int ar, input int ai, input int br, input int bi, input int sat);
    start  = 1'b1;
    x_real = W'(xr);
    x_img  = W'(xi);
    step();
    start  = 1'b0;
    x_real = W'($urandom);
    x_img  = W'($urandom);
    chk("busy_wait", int'(busy), 1);
    repeat (k - 1) step();
    prod_rdy  = 1'b1;
    prod_real = PW'(pr);
    prod_img  = PW'(pi);
    sb.push_back('{ar, ai, br, bi, sat, cyc + 2});
    step();
    prod_rdy  = 1'b0;
    prod_real = PW'($urandom);
    prod_img  = PW'($urandom);
    chk("busy_out", int'(busy), 1);
    wait_drain();
    chk("sat_hold", int'(sat_flag), sat);
    last_ar = ar; last_ai = ai; last_br = br; last_bi = bi; last_sat = sat;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_sat_flag"}, int'(sat_flag), 0);
    chk({tag, "_a_real"}, int'(a_real), 0);
    chk({tag, "_a_img"}, int'(a_img), 0);
    chk({tag, "_b_real"}, int'(b_real), 0);
    chk({tag, "_b_img"}, int'(b_img), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int xr, xi, pr, pi, k, sr, si;

    vecs[0] = '{100, 50, 20, -10, 3, 60, 20, 40, 30, 0};
    vecs[1] = '{2047, 0, 4096, 0, 1, 2047, 0, 0, 0, 1};
    vecs[2] = '{-2048, 0, -5000, 0, 2, -2048, 0, 0, 0, 1};
    vecs[3] = '{-7, 5, 3, -2, 1, -2, 1, -5, 3, 0};
    vecs[4] = '{2047, -2048, 2047, -2048, 5, 2047, -2048, 0, 0, 0};
    vecs[5] = '{0, 1000, 0, 2048, 16, 0, 1523, 0, -524, 1};
    vecs[6] = '{-1, -1, -1, 1, 1, -1, 0, 0, -1, 0};
    vecs[7] = '{1, 1, -2049, -8388608, 2, -1024, -1024, 1024, 1024, 1};

    rst_n = 1'b0; start = 1'b0; prod_rdy = 1'b0;
    x_real = '0; x_img = '0; prod_real = '0; prod_img = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    step();

    // prod_rdy alone in IDLE must not start anything
    prod_rdy = 1'b1; prod_real = 24'sd77; prod_img = 24'sd77;
    step();
    prod_rdy = 1'b0;
    chk("idle_prod_rdy_busy", int'(busy), 0);
    repeat (3) step();

    foreach (vecs[i])
      run_op(vecs[i].xr, vecs[i].xi, vecs[i].pr, vecs[i].pi, vecs[i].k,
             vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, vecs[i].sat);

    for (int i = 0; i < 6; i++) begin
      xr = int'($urandom_range(4095)) - 2048;
      xi = int'($urandom_range(4095)) - 2048;
      pr = int'($urandom_range(8191)) - 4096;
      pi = int'($urandom_range(8191)) - 4096;
      k  = int'($urandom_range(TO, 1));
      sr = sat12(pr);
      si = sat12(pi);
      run_op(xr, xi, pr, pi, k, (xr + sr) >>> 1, (xi + si) >>> 1, (xr - sr) >>> 1,
             (xi - si) >>> 1, ((sr != pr) || (si != pi)) ? 1 : 0);
    end

    // Timeout: sixteen WAIT cycles without a product
    start = 1'b1; x_real = 12'sd300; x_img = 12'sd300;
    step();
    start = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i < TO) begin
        chk("to_early_timeout", int'(timeout), 0);
        chk("to_early_busy", int'(busy), 1);
      end else begin
        chk("to_timeout", int'(timeout), 1);
        chk("to_busy", int'(busy), 0);
      end
    end
    step();
    chk("to_pulse_width", int'(timeout), 0);
    chk("to_out_valid", int'(out_valid), 0);
    chk("to_hold_a_real", int'(a_real), last_ar);
    chk("to_hold_a_img", int'(a_img), last_ai);
    chk("to_hold_b_real", int'(b_real), last_br);
    chk("to_hold_b_img", int'(b_img), last_bi);
    chk("to_hold_sat", int'(sat_flag), last_sat);

    // start+prod_rdy together in IDLE, then a second start during WAIT
    start = 1'b1; prod_rdy = 1'b1; x_real = 12'sd10; x_img = 12'sd20;
    prod_real = 24'sd500; prod_img = 24'sd500;
    step();
    start = 1'b0; prod_rdy = 1'b0;
    repeat (2) step();
    chk("dbl_busy", int'(busy), 1);
    start = 1'b1; x_real = 12'sd999; x_img = 12'sd999;
    step();
    start = 1'b0;
    step();
    prod_rdy = 1'b1; prod_real = 24'sd3000; prod_img = -24'sd40;
    sb.push_back('{1028, -10, -1019, 30, 1, cyc + 2});
    step();
    prod_rdy = 1'b0;
    wait_drain();
    repeat (4) step();
    chk("dbl_idle", int'(busy), 0);

    // Asynchronous reset in the middle of WAIT
    start = 1'b1; x_real = 12'sd111; x_img = 12'sd222;
    step();
    start = 1'b0;
    step();
    chk("rst_pre_busy", int'(busy), 1);
    chk("rst_pre_sat", int'(sat_flag), 1);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    prod_rdy = 1'b1; prod_real = 24'sd50; prod_img = 24'sd50;
    step();
    prod_rdy = 1'b0;
    repeat (4) step();
    chk("rst_post_busy", int'(busy), 0);
    chk("rst_post_a_real", int'(a_real), 0);

    run_op(vecs[0].xr, vecs[0].xi, vecs[0].pr, vecs[0].pi, vecs[0].k,
           vecs[0].ar, vecs[0].ai, vecs[0].br, vecs[0].bi, vecs[0].sat);
    repeat (4) step();
    chk("final_queue_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
